// File: rtl/i2c_slave_regfile_pkg.sv
// Shared types and defaults for the I2C register-file target.
// State encoding and default device parameters.
package i2c_slave_regfile_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV_ADDR,
    S_DEV_ACK,
    S_REG_ADDR,
    S_REG_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK
  } state_t;

  localparam logic [6:0] DEF_SLAVE_ADDR = 7'h50;
  localparam int DEF_REG_DEPTH = 16;

endpackage

// File: rtl/i2c_slave_regfile_sync.sv
// Two-flop synchronizers for scl/sda and bus event detection.
// Edges and START/STOP are derived from the synchronized copies.
module i2c_slave_regfile_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_q;
  logic [1:0] sda_q;
  logic       scl_d;
  logic       sda_d;
  logic       scl_s;

  // Synchronize lines and keep one-cycle history; idle bus is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_q <= 2'b11;
      sda_q <= 2'b11;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_q <= {scl_q[0], scl};
      sda_q <= {sda_q[0], sda};
      scl_d <= scl_q[1];
      sda_d <= sda_q[1];
    end
  end

  assign scl_s     = scl_q[1];
  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte register file and a local host port.
// Bits sampled on scl rise; sda driven low only, changed after scl fall.
module i2c_slave_regfile
  import i2c_slave_regfile_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
  parameter int         REG_DEPTH  = DEF_REG_DEPTH,
  parameter int         AW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  inout  wire           sda,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [7:0]    cfg_wdata,
  output logic [7:0]    cfg_rdata,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  localparam logic [8:0] DEPTH9 = 9'(REG_DEPTH);

  logic          sda_s;
  logic          scl_rise;
  logic          scl_fall;
  logic          start_det;
  logic          stop_det;

  state_t        state;
  logic [3:0]    cnt;
  logic [7:0]    sh;
  logic [7:0]    rx;
  logic [AW-1:0] ptr;
  logic          drv;
  logic          ph;
  logic          rw;
  logic          ack;
  logic [7:0]    regs [REG_DEPTH];

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    if (p == AW'(REG_DEPTH - 1)) return '0;
    return p + AW'(1);
  endfunction

  i2c_slave_regfile_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  assign sda       = drv ? 1'b0 : 1'bz;
  assign rx        = {sh[6:0], sda_s};
  assign cfg_rdata = regs[cfg_addr];

  // Protocol FSM, register array and commit outputs; host write wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sh        <= '0;
      ptr       <= '0;
      drv       <= 1'b0;
      ph        <= 1'b0;
      rw        <= 1'b0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (start_det) begin
        state <= S_DEV_ADDR;
        cnt   <= '0;
        drv   <= 1'b0;
        busy  <= 1'b1;
      end else if (stop_det) begin
        state <= S_IDLE;
        drv   <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_DEV_ADDR: if (scl_rise) begin
            if (cnt == 4'd7) begin
              if (rx[7:1] == SLAVE_ADDR) begin
                state <= S_DEV_ACK;
                rw    <= rx[0];
                ph    <= 1'b0;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              sh  <= rx;
              cnt <= cnt + 4'd1;
            end
          end
          S_REG_ADDR: if (scl_rise) begin
            if (cnt == 4'd7) begin
              if ({1'b0, rx} < DEPTH9) begin
                ptr   <= rx[AW-1:0];
                state <= S_REG_ACK;
                ph    <= 1'b0;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              sh  <= rx;
              cnt <= cnt + 4'd1;
            end
          end
          S_WR_DATA: if (scl_rise) begin
            if (cnt == 4'd7) begin
              regs[ptr] <= rx;
              wr_strobe <= 1'b1;
              wr_addr   <= ptr;
              wr_data   <= rx;
              ptr       <= inc(ptr);
              state     <= S_WR_ACK;
              ph        <= 1'b0;
            end else begin
              sh  <= rx;
              cnt <= cnt + 4'd1;
            end
          end
          S_DEV_ACK, S_REG_ACK, S_WR_ACK: begin
            if (scl_rise) ph <= 1'b1;
            if (scl_fall && !ph) drv <= 1'b1;
            if (scl_fall && ph) begin
              drv <= 1'b0;
              cnt <= '0;
              ph  <= 1'b0;
              if (state == S_DEV_ACK && rw) begin
                sh    <= regs[ptr];
                drv   <= ~regs[ptr][7];
                state <= S_RD_DATA;
              end else if (state == S_DEV_ACK) begin
                state <= S_REG_ADDR;
              end else begin
                state <= S_WR_DATA;
              end
            end
          end
          S_RD_DATA: begin
            if (scl_rise) begin
              sh  <= {sh[6:0], 1'b0};
              cnt <= cnt + 4'd1;
            end
            if (scl_fall) begin
              if (cnt == 4'd8) begin
                drv   <= 1'b0;
                ph    <= 1'b0;
                state <= S_RD_ACK;
              end else begin
                drv <= ~sh[7];
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              ph  <= 1'b1;
              ack <= ~sda_s;
              if (!sda_s) ptr <= inc(ptr);
            end
            if (scl_fall && ph) begin
              ph <= 1'b0;
              if (ack) begin
                sh    <= regs[ptr];
                drv   <= ~regs[ptr][7];
                cnt   <= '0;
                state <= S_RD_DATA;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
      if (cfg_we) regs[cfg_addr] <= cfg_wdata;
    end
  end

endmodule
